vend_txn_sequencer: RTL and testbench
=====================================

VEND_TXN_SEQUENCER -- requirements
Module: vend_txn_sequencer

Interface
REQ-001 SHALL have parameter PRICE_NEWS, default 5, price of newspaper in Rs.
REQ-002 SHALL have parameter PRICE_BAR, default 10, price of cadbury bar in Rs.
REQ-003 SHALL have parameter PRICE_JUICE, default 15, price of tropicana juice in Rs.
REQ-004 SHALL have parameter MAX_CREDIT, default 30, credit ceiling in Rs (multiple of 5, <=31).
REQ-005 SHALL have parameter TIMEOUT, default 200, idle cycles in CREDIT before auto-cancel (1..255).
REQ-006 clock  input  1  rising-edge clock for all state.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 coin_valid  input  1  one-cycle strobe, coin present on coin_value.
REQ-009 coin_value  input  5  coin denomination; legal values 5, 10, 20.
REQ-010 select_valid  input  1  one-cycle strobe, product present on select_product.
REQ-011 select_product  input  2  01 newspaper, 10 bar, 11 juice, 00 none.
REQ-012 cancel  input  1  one-cycle strobe, refund request.
REQ-013 disp_req  output  1  dispense request to dispenser, held until disp_ack.
REQ-014 disp_item  output  2  product code being dispensed, stable while disp_req high.
REQ-015 disp_ack  input  1  dispenser accepts request.
REQ-016 chg_req  output  1  request to eject one Rs.5 change coin, held until chg_ack.
REQ-017 chg_ack  input  1  change coin ejected.
REQ-018 credit  output  5  current accumulated credit in Rs.
REQ-019 busy  output  1  high in any state other than IDLE.
REQ-020 coin_reject  output  1  one-cycle pulse, coin returned unaccepted.
REQ-021 err_insufficient  output  1  one-cycle pulse, selection refused for lack of credit.
REQ-022 done  output  1  one-cycle pulse, transaction complete, returning to IDLE.

Function
REQ-023 SHALL implement states IDLE, CREDIT, DISPENSE, CHANGE; all outputs registered.
REQ-024 IDLE: credit 0; legal coin_valid -> credit=coin_value, go CREDIT; cancel/select ignored.
REQ-025 Illegal coin_value (not 5/10/20) in any state -> coin_reject pulse next cycle, credit unchanged.
REQ-026 CREDIT: legal coin with credit+coin<=MAX_CREDIT -> credit+=coin; else coin_reject, credit unchanged; sum computed 6-bit, no wrap.
REQ-027 CREDIT: select_valid with product!=00 and credit>=price -> credit-=price, latch disp_item, go DISPENSE.
REQ-028 CREDIT: select_valid with credit<price -> err_insufficient pulse, stay CREDIT, credit unchanged; product 00 ignored.
REQ-029 CREDIT: cancel -> go CHANGE (credit always >0 in CREDIT).
REQ-030 Same-cycle priority in CREDIT: cancel > select > coin; coin arriving with cancel or select SHALL be rejected.
REQ-031 CREDIT timeout counter SHALL clear on entry and on any accepted coin or select strobe; reaching TIMEOUT -> behave as cancel.
REQ-032 DISPENSE: disp_req=1 from the cycle after select acceptance until the cycle disp_ack is sampled high; deasserted next cycle.
REQ-033 On disp_ack: credit>0 -> CHANGE; credit==0 -> IDLE with done pulse.
REQ-034 CHANGE: chg_req=1; each cycle chg_ack sampled high -> credit-=5 and chg_req drops for one cycle; credit reaching 0 -> IDLE, done pulse, chg_req 0.
REQ-035 Any coin_valid in DISPENSE or CHANGE SHALL produce coin_reject; select/cancel ignored there.
REQ-036 disp_ack outside DISPENSE and chg_ack outside CHANGE SHALL be ignored.

Reset
REQ-037 reset SHALL force IDLE, credit 0, timeout counter 0, and all outputs 0 on the next clock edge, including mid-DISPENSE/CHANGE (credit discarded).
REQ-038 reset SHALL take priority over every other input in the same cycle.

Verification
REQ-039 coin 10, select 10 -> disp_req=1, disp_item=10; disp_ack -> done pulse, credit 0, chg_req never high.
REQ-040 coin 20, select 11 -> dispense juice, then one chg_req/chg_ack pair, credit 5->0, done.
REQ-041 coin 5, select 10 -> err_insufficient pulse, credit 5; coin 5, select 10 -> dispense bar, credit 0.
REQ-042 coins 20, 10, 5 -> third coin_reject, credit 30; coin 7 in IDLE -> coin_reject, busy 0.
REQ-043 coin 10, cancel -> two chg_req/chg_ack handshakes, credit 10->5->0, done; coin 5 then TIMEOUT idle cycles -> one change coin.
REQ-044 coin 20, select 01, reset while disp_req high -> next cycle all outputs 0, credit 0, busy 0.

Source files
------------

// File: rtl/vend_txn_sequencer.sv
// Vending transaction sequencer: coin credit, product dispense and
// Rs.5 change ejection with registered handshake outputs.
module vend_txn_sequencer #(
  parameter int PRICE_NEWS  = 5,
  parameter int PRICE_BAR   = 10,
  parameter int PRICE_JUICE = 15,
  parameter int MAX_CREDIT  = 30,
  parameter int TIMEOUT     = 200
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       coin_valid,
  input  logic [4:0] coin_value,
  input  logic       select_valid,
  input  logic [1:0] select_product,
  input  logic       cancel,
  output logic       disp_req,
  output logic [1:0] disp_item,
  input  logic       disp_ack,
  output logic       chg_req,
  input  logic       chg_ack,
  output logic [4:0] credit,
  output logic       busy,
  output logic       coin_reject,
  output logic       err_insufficient,
  output logic       done
);

  typedef enum logic [1:0] {
    S_IDLE, S_CREDIT, S_DISP, S_CHANGE
  } state_t;

  localparam logic [5:0] MAX_C = 6'(MAX_CREDIT);
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  logic [7:0] tmr;
  logic       coin_ok;
  logic       sel_on;
  logic [5:0] sum;
  logic [4:0] price;

  always_comb begin
    coin_ok = coin_valid &&
      (coin_value == 5'd5 || coin_value == 5'd10 ||
       coin_value == 5'd20);
    sel_on = select_valid && (select_product != 2'b00);
    sum = {1'b0, credit} + {1'b0, coin_value};
    price = 5'd0;
    unique case (select_product)
      2'b01:   price = 5'(PRICE_NEWS);
      2'b10:   price = 5'(PRICE_BAR);
      2'b11:   price = 5'(PRICE_JUICE);
      default: price = 5'd0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state            <= S_IDLE;
      tmr              <= 8'd0;
      credit           <= 5'd0;
      disp_req         <= 1'b0;
      disp_item        <= 2'b00;
      chg_req          <= 1'b0;
      busy             <= 1'b0;
      coin_reject      <= 1'b0;
      err_insufficient <= 1'b0;
      done             <= 1'b0;
    end else begin
      coin_reject      <= 1'b0;
      err_insufficient <= 1'b0;
      done             <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (coin_ok) begin
            credit <= coin_value;
            tmr    <= 8'd0;
            busy   <= 1'b1;
            state  <= S_CREDIT;
          end else begin
            coin_reject <= coin_valid;
          end
        end
        S_CREDIT: begin
          if (cancel) begin
            coin_reject <= coin_valid;
            chg_req     <= 1'b1;
            tmr         <= 8'd0;
            state       <= S_CHANGE;
          end else if (sel_on) begin
            coin_reject <= coin_valid;
            tmr         <= 8'd0;
            if (credit >= price) begin
              credit    <= credit - price;
              disp_item <= select_product;
              disp_req  <= 1'b1;
              state     <= S_DISP;
            end else begin
              err_insufficient <= 1'b1;
            end
          end else if (coin_ok && sum <= MAX_C) begin
            credit <= sum[4:0];
            tmr    <= 8'd0;
          end else begin
            // idle cycle (rejected coins do not count as activity)
            coin_reject <= coin_valid;
            if (tmr == TMO_LAST) begin
              chg_req <= 1'b1;
              tmr     <= 8'd0;
              state   <= S_CHANGE;
            end else begin
              tmr <= tmr + 8'd1;
            end
          end
        end
        S_DISP: begin
          coin_reject <= coin_valid;
          if (disp_ack) begin
            disp_req <= 1'b0;
            if (credit != 5'd0) begin
              chg_req <= 1'b1;
              state   <= S_CHANGE;
            end else begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_IDLE;
            end
          end
        end
        S_CHANGE: begin
          coin_reject <= coin_valid;
          if (chg_req && chg_ack) begin
            credit  <= credit - 5'd5;
            chg_req <= 1'b0;
            if (credit == 5'd5) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_IDLE;
            end
          end else begin
            chg_req <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vend_txn_sequencer.sv
// Bench for vend_txn_sequencer: directed scenarios plus randomized
// transactions checked against a credit-arithmetic reference model.
module tb_vend_txn_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       coin_valid = 1'b0;
  logic [4:0] coin_value = 5'd0;
  logic       select_valid = 1'b0;
  logic [1:0] select_product = 2'b00;
  logic       cancel = 1'b0;
  logic       disp_req;
  logic [1:0] disp_item;
  logic       disp_ack = 1'b0;
  logic       chg_req;
  logic       chg_ack = 1'b0;
  logic [4:0] credit;
  logic       busy;
  logic       coin_reject;
  logic       err_insufficient;
  logic       done;

  always #5 clock = ~clock;

  vend_txn_sequencer dut (
    .clock(clock),
    .reset(reset),
    .coin_valid(coin_valid),
    .coin_value(coin_value),
    .select_valid(select_valid),
    .select_product(select_product),
    .cancel(cancel),
    .disp_req(disp_req),
    .disp_item(disp_item),
    .disp_ack(disp_ack),
    .chg_req(chg_req),
    .chg_ack(chg_ack),
    .credit(credit),
    .busy(busy),
    .coin_reject(coin_reject),
    .err_insufficient(err_insufficient),
    .done(done)
  );

  int total = 0;
  int bad = 0;
  int m_credit = 0;
  bit m_busy = 1'b0;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  function automatic int price(input int p);
    case (p)
      1: return 5;
      2: return 10;
      3: return 15;
      default: return 0;
    endcase
  endfunction

  task automatic resync();
    reset = 1'b1;
    step();
    reset = 1'b0;
    m_credit = 0;
    m_busy = 1'b0;
  endtask

  task automatic coin(input int v);
    bit acc;
    acc = (v == 5 || v == 10 || v == 20) &&
          (m_credit + v <= 30);
    coin_valid = 1'b1;
    coin_value = 5'(v);
    step();
    coin_valid = 1'b0;
    if (acc) begin
      m_credit += v;
      m_busy = 1'b1;
    end
    chk("coin_reject", coin_reject, int'(!acc));
    chk("coin_credit", credit, m_credit);
    chk("coin_busy", busy, int'(m_busy));
  endtask

  task automatic serve_change();
    while (m_credit > 0) begin
      int n;
      n = 0;
      while (chg_req !== 1'b1 && n < 300) begin
        step();
        n++;
      end
      chk("chg_wait", int'(n < 300), 1);
      if (n >= 300) begin
        resync();
        return;
      end
      repeat ($urandom_range(0, 2)) begin
        chk("chg_hold", chg_req, 1);
        step();
      end
      chg_ack = 1'b1;
      step();
      chg_ack = 1'b0;
      m_credit -= 5;
      chk("chg_drop", chg_req, 0);
      chk("chg_credit", credit, m_credit);
      if (m_credit == 0) begin
        m_busy = 1'b0;
        chk("chg_done", done, 1);
        chk("chg_busy", busy, 0);
      end else begin
        chk("chg_nodone", done, 0);
      end
    end
  endtask

  task automatic do_select(input int p);
    int pr;
    pr = price(p);
    select_valid = 1'b1;
    select_product = 2'(p);
    step();
    select_valid = 1'b0;
    if (!m_busy) begin
      chk("sel_idle_busy", busy, 0);
      chk("sel_idle_err", err_insufficient, 0);
    end else if (m_credit >= pr) begin
      m_credit -= pr;
      chk("disp_req", disp_req, 1);
      chk("disp_item", disp_item, p);
      chk("disp_credit", credit, m_credit);
      chk("disp_noerr", err_insufficient, 0);
      repeat ($urandom_range(0, 3)) begin
        bit c;
        c = 1'($urandom_range(0, 1));
        coin_valid = c;
        coin_value = 5'd10;
        step();
        coin_valid = 1'b0;
        chk("disp_hold", disp_req, 1);
        chk("disp_coin_rej", coin_reject, int'(c));
        chk("disp_hold_cr", credit, m_credit);
      end
      disp_ack = 1'b1;
      step();
      disp_ack = 1'b0;
      chk("disp_drop", disp_req, 0);
      if (m_credit == 0) begin
        m_busy = 1'b0;
        chk("disp_done", done, 1);
        chk("disp_busy", busy, 0);
        chk("disp_nochg", chg_req, 0);
      end else begin
        serve_change();
      end
    end else begin
      chk("sel_err", err_insufficient, 1);
      chk("sel_err_cr", credit, m_credit);
      chk("sel_err_busy", busy, 1);
      chk("sel_err_nodisp", disp_req, 0);
    end
  endtask

  task automatic do_cancel();
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    if (m_busy) begin
      chk("cancel_busy", busy, 1);
      chk("cancel_cr", credit, m_credit);
      serve_change();
    end else begin
      chk("cancel_idle", busy, 0);
      chk("cancel_idle_chg", chg_req, 0);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_disp"}, disp_req, 0);
    chk({tag, "_chg"}, chg_req, 0);
    chk({tag, "_credit"}, credit, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_rej"}, coin_reject, 0);
    chk({tag, "_err"}, err_insufficient, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  int vals[7] = '{5, 10, 20, 7, 15, 0, 31};

  initial begin
    step();
    step();
    chk_all_zero("reset");
    reset = 1'b0;
    step();

    coin(10);
    do_select(2);

    coin(20);
    do_select(3);

    coin(5);
    do_select(2);
    coin(5);
    do_select(2);

    coin(20);
    coin(10);
    coin(5);
    chk("max_credit", credit, 30);
    do_cancel();
    coin(7);

    coin(10);
    do_cancel();
    do_cancel();

    coin(5);
    repeat (150) step();
    chk("tmo_wait_chg", chg_req, 0);
    chk("tmo_wait_busy", busy, 1);
    serve_change();

    coin(5);
    cancel = 1'b1;
    coin_valid = 1'b1;
    coin_value = 5'd5;
    step();
    cancel = 1'b0;
    coin_valid = 1'b0;
    chk("prio_rej", coin_reject, 1);
    chk("prio_cr", credit, 5);
    serve_change();

    coin(20);
    select_valid = 1'b1;
    select_product = 2'b01;
    step();
    select_valid = 1'b0;
    chk("rst_pre_disp", disp_req, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    m_credit = 0;
    m_busy = 1'b0;
    chk_all_zero("mid_reset");

    repeat (25) begin
      repeat ($urandom_range(1, 4))
        coin(vals[$urandom_range(0, 6)]);
      if (m_busy) begin
        int r;
        r = $urandom_range(0, 3);
        if (r == 0) begin
          do_cancel();
        end else begin
          do_select(r);
          if (m_busy) do_cancel();
        end
      end
    end
    chk("end_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
